bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/seg7_pkg.sv | 16 +
 rtl/bcd_digit_adj.sv | 13 +
 rtl/bin2bcd_seq.sv | 111 +++++++++++
 tb/tb_bin2bcd_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the binary-to-BCD front end of the 7-segment display
// path: FSM state encoding, BCD result width and the largest value that four
// decimal digits can show.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int              BCD_W   = 16;
    localparam int              MAX_DEC = 9999;
    localparam logic [BCD_W-1:0] BCD_SAT = 16'h9999;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next decade.
// Ports:
//   din  - current scratch digit (0..15 tolerated, 0..9 in normal use)
//   dout - corrected digit, ready to be shifted
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// A value is accepted on in_valid && in_ready, converted over IN_W cycles and
// presented as four packed BCD digits with a one-cycle out_valid pulse.
// Values above 9999 saturate to 9999 and raise ovf.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   bin       - unsigned binary input (IN_W bits)
//   in_valid  - bin is valid this cycle
//   in_ready  - converter can accept a value this cycle
//   bcd       - packed BCD result, [15:12] thousands .. [3:0] units
//   out_valid - one-cycle pulse when a new bcd result is loaded
//   ovf       - last result was saturated
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int IN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BCD_W-1:0] bcd,
    output logic             out_valid,
    output logic             ovf
);

    state_t            state;
    logic [3:0]        cnt;
    logic [BCD_W-1:0]  scratch;
    logic [IN_W-1:0]   shreg;
    logic              sat;

    logic [BCD_W-1:0]  scr_adj;
    logic [BCD_W-1:0]  scr_next;
    logic              sat_next;
    logic              accept;

    function automatic logic [BCD_W-1:0] sat_bcd(input logic over,
                                                 input logic [BCD_W-1:0] raw);
        return over ? BCD_SAT : raw;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[4*g +: 4]),
            .dout (scr_adj[4*g +: 4])
        );
    end

    assign accept   = in_valid && in_ready;
    assign scr_next = {scr_adj[BCD_W-2:0], shreg[IN_W-1]};
    // A bit leaving the thousands digit also means the value exceeds 9999.
    assign sat_next = sat | scr_adj[BCD_W-1];

    // Binary operand and saturation flag: pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= bin;
            sat   <= (32'(bin) > MAX_DEC);
        end else if (state == SHIFT) begin
            shreg <= shreg << 1;
            sat   <= sat_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            cnt       <= 4'd0;
            scratch   <= '0;
            bcd       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // in_ready is high in both states, so in_valid alone accepts.
                    if (in_valid) begin
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        scratch  <= '0;
                        cnt      <= 4'(IN_W);
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch <= scr_next;
                    cnt     <= cnt - 4'd1;
                    // Last shift: counter lands on zero and the result is final.
                    if (cnt == 4'd1) begin
                        state     <= DONE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b1;
                        bcd       <= sat_bcd(sat_next, scr_next);
                        ovf       <= sat_next;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    localparam int IN_W = 14;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [IN_W-1:0] bin;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     bcd;
    logic            out_valid;
    logic            ovf;

    bin2bcd_seq #(.IN_W(IN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd       (bcd),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   pulses = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [16:0] ref_model(input int v);
        if (v > 9999) return {1'b1, 16'h9999};
        return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                pulses++;
                chk("pulse_width", 32'(ov_prev), 32'(0));
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: bcd=%h with nothing pending", bcd);
                end else begin
                    mon_e = sb.pop_front();
                    chk("bcd", 32'(bcd), 32'(mon_e.bcd));
                    chk("ovf", 32'(ovf), 32'(mon_e.ovf));
                    chk("latency", 32'(cyc), 32'(mon_e.due));
                    for (int i = 0; i < 4; i++)
                        chk("nibble_range", 32'(bcd[4*i +: 4] <= 4'd9), 32'(1));
                end
            end
            ov_prev = out_valid;
        end else begin
            ov_prev = 1'b0;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    // with in_valid still asserted.
    task automatic send(input logic [IN_W-1:0] v, input logic [15:0] eb, input logic eo);
        int n = 0;
        bin      = v;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b, expected 1 within 100 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        sb.push_back('{bcd: eb, ovf: eo, due: cyc + 14});
    endtask

    task automatic send_one(input logic [IN_W-1:0] v, input logic [15:0] eb, input logic eo);
        send(v, eb, eo);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        chk("pulse_end", 32'(out_valid), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, p0;
        logic [IN_W-1:0] rv;
        logic [16:0]     m;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        bin      = '0;
        repeat (3) @(negedge clk);
        chk("rst_bcd", 32'(bcd), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'(1));

        // Zero input
        send_one(14'd0, 16'h0000, 1'b0);
        drain();

        // 1234 with busy check, then 9999
        send_one(14'd1234, 16'h1234, 1'b0);
        repeat (13) begin
            @(negedge clk);
            chk("in_ready_busy", 32'(in_ready), 32'(0));
        end
        @(negedge clk);
        chk("in_ready_done", 32'(in_ready), 32'(1));
        drain();
        send_one(14'd9999, 16'h9999, 1'b0);
        drain();

        // Saturation then small value
        send_one(14'd16383, 16'h9999, 1'b1);
        drain();
        send_one(14'd5, 16'h0005, 1'b0);
        drain();

        // Back-to-back: 777 held during SHIFT, accepted in DONE
        send(14'd42, 16'h0042, 1'b0);
        a1 = cyc;
        send(14'd777, 16'h0777, 1'b0);
        a2 = cyc;
        in_valid = 1'b0;
        chk("b2b_spacing", 32'(a2 - a1), 32'(15));
        drain();

        // Reset mid-conversion
        send_one(14'd8888, 16'h8888, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_bcd", 32'(bcd), 32'(0));
        chk("abort_out_valid", 32'(out_valid), 32'(0));
        chk("abort_ovf", 32'(ovf), 32'(0));
        chk("abort_in_ready", 32'(in_ready), 32'(1));
        sb.delete();
        p0 = pulses;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_pulse_after_abort", 32'(pulses), 32'(p0));
        chk("abort_idle_ready", 32'(in_ready), 32'(1));
        send_one(14'd31, 16'h0031, 1'b0);
        drain();

        // Decade boundaries
        send_one(14'd10000, 16'h9999, 1'b1);
        drain();
        send_one(14'd99, 16'h0099, 1'b0);
        drain();
        send_one(14'd100, 16'h0100, 1'b0);
        drain();
        send_one(14'd1000, 16'h1000, 1'b0);
        drain();
        send_one(14'd8191, 16'h8191, 1'b0);
        drain();

        // Random sweep, back-to-back, against the decimal reference model
        for (int k = 0; k < 24; k++) begin
            rv = 14'($urandom_range(0, 16383));
            m  = ref_model(int'(rv));
            send(rv, m[15:0], m[16]);
        end
        in_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
